tb_sim_ctrl: RTL and testbench

Memory-mapped simulation controller for the verilator core testbench. It sequences core start-up by holding fetch enable off until a boot delay has elapsed after reset. Firmware writes to it to report pass, fail or an exit code, and a cycle watchdog ends runaway tests. It sits on the data bus next to the RAM and the stdout peripheral, and drives the testbench's tests_passed/tests_failed/exit_valid/exit_value signals.

---
 rtl/tb_sim_ctrl_pkg.sv | 20 ++
 rtl/tb_sim_ctrl.sv | 139 +++++++++++++
 tb/tb_tb_sim_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/tb_sim_ctrl_pkg.sv
// Shared definitions for the simulation controller: register offsets,
// CTRL command codes and the FSM state type.
package tb_sim_ctrl_pkg;

    localparam logic [4:0] OFF_CTRL      = 5'h00;
    localparam logic [4:0] OFF_EXIT      = 5'h04;
    localparam logic [4:0] OFF_CYCLE_LO  = 5'h08;
    localparam logic [4:0] OFF_CYCLE_HI  = 5'h0C;
    localparam logic [4:0] OFF_MAXCYCLES = 5'h10;

    localparam logic [31:0] CMD_PASS = 32'd1;
    localparam logic [31:0] CMD_FAIL = 32'd2;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/tb_sim_ctrl.sv
// Simulation controller: boot sequencing of fetch enable, firmware
// pass/fail/exit reporting, 64-bit cycle counter and cycle watchdog.
module tb_sim_ctrl
    import tb_sim_ctrl_pkg::*;
#(
    parameter int unsigned BOOT_DELAY         = 4,
    parameter logic [31:0] MAX_CYCLES_DEFAULT = 32'd0,
    parameter int unsigned ADDR_WIDTH         = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic [31:0]           data_rdata_o,
    output logic                  fetch_enable_o,
    output logic                  tests_passed_o,
    output logic                  tests_failed_o,
    output logic                  exit_valid_o,
    output logic [31:0]           exit_value_o,
    output logic                  timeout_o
);

    state_e      state_q, state_d;
    logic [31:0] boot_q;
    logic [63:0] cycle_q;
    logic [31:0] hi_q;
    logic [31:0] maxc_q;
    logic        passed_q, failed_q, exitv_q, timeout_q;
    logic [31:0] exitval_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;

    logic [2:0]  sel;
    logic        wr, rd, in_run;
    logic        hit_ctrl, hit_exit, hit_lo, hit_hi, hit_max;
    logic        cmd_pass, cmd_fail, report, expire, boot_done;
    logic [31:0] rmux;
    logic        unused_addr;

    assign unused_addr = ^{data_addr_i[ADDR_WIDTH-1:5], data_addr_i[1:0]};

    assign data_gnt_o = data_req_i;
    assign sel        = data_addr_i[4:2];
    assign wr         = data_req_i & data_we_i;
    assign rd         = data_req_i & ~data_we_i;
    assign in_run     = (state_q == RUN);

    assign hit_ctrl = (sel == OFF_CTRL[4:2]);
    assign hit_exit = (sel == OFF_EXIT[4:2]);
    assign hit_lo   = (sel == OFF_CYCLE_LO[4:2]);
    assign hit_hi   = (sel == OFF_CYCLE_HI[4:2]);
    assign hit_max  = (sel == OFF_MAXCYCLES[4:2]);

    // Reports count only in RUN, so the first one is final.
    assign cmd_pass  = in_run & wr & hit_ctrl & (data_wdata_i == CMD_PASS);
    assign cmd_fail  = in_run & wr & hit_ctrl & (data_wdata_i == CMD_FAIL);
    assign report    = cmd_pass | cmd_fail | (in_run & wr & hit_exit);
    assign expire    = in_run & (maxc_q != 32'd0) & (cycle_q >= {32'd0, maxc_q});
    assign boot_done = ((boot_q + 32'd1) >= BOOT_DELAY);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= BOOT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    if (boot_done) state_d = RUN;
            RUN:     if (report || expire) state_d = DONE;
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        fetch_enable_o = (state_q != BOOT);
    end

    always_comb begin
        rmux = 32'd0;
        case (sel)
            OFF_CTRL[4:2]:      rmux = {30'd0, failed_q, passed_q};
            OFF_EXIT[4:2]:      rmux = exitval_q;
            OFF_CYCLE_LO[4:2]:  rmux = cycle_q[31:0];
            OFF_CYCLE_HI[4:2]:  rmux = hi_q;
            OFF_MAXCYCLES[4:2]: rmux = maxc_q;
            default:            rmux = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            boot_q    <= 32'd0;
            cycle_q   <= 64'd0;
            hi_q      <= 32'd0;
            maxc_q    <= MAX_CYCLES_DEFAULT;
            passed_q  <= 1'b0;
            failed_q  <= 1'b0;
            exitv_q   <= 1'b0;
            exitval_q <= 32'd0;
            timeout_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            if (state_q == BOOT) boot_q <= boot_q + 32'd1;
            // The counter freezes on the edge that leaves RUN.
            if (in_run && state_d == RUN) cycle_q <= cycle_q + 64'd1;
            if (rd && hit_lo) hi_q <= cycle_q[63:32];
            if (wr && hit_max) begin
                for (int i = 0; i < 4; i++)
                    if (data_be_i[i]) maxc_q[8*i +: 8] <= data_wdata_i[8*i +: 8];
            end
            if (cmd_pass) passed_q <= 1'b1;
            if (cmd_fail) failed_q <= 1'b1;
            if (in_run && wr && hit_exit) begin
                exitv_q   <= 1'b1;
                exitval_q <= data_wdata_i;
            end
            // A firmware report in the same cycle pre-empts the watchdog.
            if (expire && !report) timeout_q <= 1'b1;
            rvalid_q <= data_req_i;
            rdata_q  <= rd ? rmux : 32'd0;
        end
    end

    assign data_rvalid_o  = rvalid_q;
    assign data_rdata_o   = rdata_q;
    assign tests_passed_o = passed_q;
    assign tests_failed_o = failed_q;
    assign exit_valid_o   = exitv_q;
    assign exit_value_o   = exitval_q;
    assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_tb_sim_ctrl.sv
// Randomized bench for tb_sim_ctrl against a cycle-level behavioural model
// built from the controller's register/boot/watchdog rules.
module tb_tb_sim_ctrl;

    localparam int unsigned BD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [3:0]  be = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        gnt, rvalid, fetch, passed, failed, exitv, tmo;
    logic [31:0] rdata, exitval;

    always #5 clk = ~clk;

    tb_sim_ctrl #(.BOOT_DELAY(BD), .MAX_CYCLES_DEFAULT(32'd0), .ADDR_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be),
        .data_wdata_i(wdata), .data_rdata_o(rdata),
        .fetch_enable_o(fetch), .tests_passed_o(passed), .tests_failed_o(failed),
        .exit_valid_o(exitv), .exit_value_o(exitval), .timeout_o(tmo)
    );

    int n_vec = 0, n_err = 0;

    // Model: phase 0 = booting, 1 = running, 2 = finished.
    int          m_phase, m_boot;
    logic [63:0] m_cnt;
    logic [31:0] m_hi, m_max, m_exitval, m_rd;
    bit          m_pass, m_fail, m_exitv, m_to, m_rv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input int idx);
        case (idx)
            0:       return {30'd0, m_fail, m_pass};
            1:       return m_exitval;
            2:       return m_cnt[31:0];
            3:       return m_hi;
            4:       return m_max;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit q, input bit w, input logic [31:0] a,
                              input logic [3:0] b, input logic [31:0] d);
        int  idx;
        bit  rep;
        idx = int'(a[4:2]);
        if (r) begin
            m_phase = 0; m_boot = 0; m_cnt = 64'd0; m_hi = 0; m_max = 0;
            m_pass = 0; m_fail = 0; m_exitv = 0; m_exitval = 0; m_to = 0;
            m_rv = 0; m_rd = 0;
            return;
        end
        m_rv = q;
        m_rd = (q && !w) ? m_read(idx) : 32'd0;
        if (q && !w && idx == 2) m_hi = m_cnt[63:32];
        rep = 0;
        if (m_phase == 1 && q && w) begin
            if (idx == 0 && d == 1) begin m_pass = 1; rep = 1; end
            if (idx == 0 && d == 2) begin m_fail = 1; rep = 1; end
            if (idx == 1) begin m_exitv = 1; m_exitval = d; rep = 1; end
        end
        if (m_phase == 0) begin
            m_boot++;
            if (m_boot >= int'(BD)) m_phase = 1;
        end else if (m_phase == 1) begin
            if (rep) m_phase = 2;
            else if (m_max != 0 && m_cnt >= {32'd0, m_max}) begin m_to = 1; m_phase = 2; end
            else m_cnt = m_cnt + 64'd1;
        end
        // MAXCYCLES update after the watchdog looked at the old value.
        if (q && w && idx == 4)
            for (int i = 0; i < 4; i++) if (b[i]) m_max[8*i +: 8] = d[8*i +: 8];
    endtask

    // One bus cycle: drive at negedge, model on posedge, compare at negedge.
    task automatic step(input bit r, input bit q, input bit w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
        rst = r; req = q; we = w; addr = a; be = b; wdata = d;
        #1 chk("gnt", gnt, q);
        @(posedge clk);
        model_edge(r, q, w, a, b, d);
        @(negedge clk);
        chk("fetch", fetch, m_phase != 0);
        chk("passed", passed, m_pass);
        chk("failed", failed, m_fail);
        chk("exit_valid", exitv, m_exitv);
        chk("exit_value", exitval, m_exitval);
        chk("timeout", tmo, m_to);
        chk("rvalid", rvalid, m_rv);
        chk("rdata", rdata, m_rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'd0, 4'd0, 32'd0);
    endtask
    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        step(0, 1, 1, a, b, d);
    endtask
    task automatic rd_reg(input logic [31:0] a);
        step(0, 1, 0, a, 4'hF, $urandom);
    endtask
    task automatic do_reset();
        step(1, 0, 0, 32'd0, 4'd0, 32'd0);
        step(1, $urandom_range(0, 1), 0, 32'h8, 4'hF, 32'd0);
    endtask

    task automatic rand_step();
        int          idx;
        bit          q, w, r;
        logic [31:0] a, d;
        idx = $urandom_range(0, 7);
        q   = bit'($urandom_range(0, 1));
        w   = q && ((idx <= 1) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0));
        a   = $urandom;
        a[4:2] = 3'(idx);
        d   = (idx == 0 && $urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
        if (idx == 4 && $urandom_range(0, 1) == 1) d = 32'($urandom_range(0, 300));
        r   = ($urandom_range(0, 199) == 0);
        step(r, q, w, a, 4'($urandom_range(0, 15)), d);
    endtask

    initial begin
        logic [31:0] lo, hi;
        logic [63:0] base;
        int          guard;

        @(negedge clk);
        do_reset();
        chk("rst_fetch", fetch, 0);
        chk("rst_rvalid", rvalid, 0);

        // Start-up: fetch enable rises on the BD-th edge after reset.
        for (int i = 1; i <= 8; i++) begin
            rd_reg(32'h8);
            if (i == int'(BD) - 1) chk("fetch_pre", fetch, 0);
            if (i == int'(BD))     chk("fetch_on", fetch, 1);
        end

        // Pass report; a later fail write is ignored.
        wr_reg(32'h0, 32'd1, 4'hF);
        chk("pass_set", passed, 1);
        rd_reg(32'h0);
        chk("ctrl_read", rdata, 32'd1);
        wr_reg(32'h0, 32'd2, 4'hF);
        chk("fail_ignored", failed, 0);
        idle(2);

        // Exit code.
        do_reset();
        idle(6);
        wr_reg(32'h4, 32'h0000_002A, 4'h0);
        chk("exit_v", exitv, 1);
        chk("exit_42", exitval, 32'd42);
        rd_reg(32'h4);
        chk("exit_read", rdata, 32'h2A);

        // Watchdog with a single-byte MAXCYCLES write during boot.
        do_reset();
        wr_reg(32'h10, 32'hA5A5_A564, 4'b0001);
        guard = 0;
        while (m_phase != 2 && guard < 300) begin idle(1); guard++; end
        chk("wd_fired", tmo, 1);
        idle(3);
        rd_reg(32'h8);
        chk("wd_frozen_lo", rdata, 32'd100);

        // Firmware fail lands in the watchdog-expiry cycle.
        do_reset();
        wr_reg(32'h10, 32'd50, 4'hF);
        guard = 0;
        while (m_cnt != 64'd50 && m_phase != 2 && guard < 200) begin idle(1); guard++; end
        wr_reg(32'h0, 32'd2, 4'hF);
        chk("sim_failed", failed, 1);
        chk("sim_no_timeout", tmo, 0);

        // Coherent 64-bit read across the low-word wrap.
        do_reset();
        idle(6);
        base = 64'h0000_0000_FFFF_FFF8;
        force dut.cycle_q = base;
        #1 release dut.cycle_q;
        m_cnt = base;
        for (int i = 0; i < 10; i++) begin
            rd_reg(32'h8);
            lo = rdata;
            rd_reg(32'hC);
            hi = rdata;
            chk("coherent64", ({hi, lo} >= base) && ({hi, lo} < base + 64'd64), 1);
        end
        chk("wrapped_hi", hi, 32'd1);

        // Mid-run reset returns everything to the boot state.
        rd_reg(32'h8);
        step(1, 0, 0, 32'd0, 4'd0, 32'd0);
        chk("midrst_fetch", fetch, 0);
        chk("midrst_rvalid", rvalid, 0);

        // Randomized episodes.
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            if (ep % 2 == 0) wr_reg(32'h10, 32'($urandom_range(20, 200)), 4'hF);
            for (int i = 0; i < 250; i++) rand_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
